// File: rtl/alu.sv
// 32-bit ALU with a registered 64-bit result and one-cycle latency.
// Define ALU_FLAGS_EN to add the registered zero_flag / neg_flag outputs.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     input_a,
    input  logic [WIDTH-1:0]     input_b,
    input  logic [3:0]           opcode,
    output logic [2*WIDTH-1:0]   ALU_result
`ifdef ALU_FLAGS_EN
    ,
    output logic                 zero_flag,
    output logic                 neg_flag
`endif
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_OR   = 4'd0,
        OP_AND  = 4'd1,
        OP_NOT  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_NEG  = 4'd5,
        OP_MUL  = 4'd6,
        OP_DIV  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_SHRA = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12
    } op_e;

    logic [SW-1:0]          amt;
    logic [WIDTH-1:0]       shl_res;
    logic [WIDTH-1:0]       shr_res;
    logic [WIDTH-1:0]       shra_res;
    logic [2*WIDTH-1:0]     rol_wide;
    logic [2*WIDTH-1:0]     ror_wide;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]       quot;
    logic [WIDTH-1:0]       rem;
    logic [2*WIDTH-1:0]     result_d;
    logic [2*WIDTH-1:0]     result_q;

    assign amt      = input_b[SW-1:0];
    assign shl_res  = input_a << amt;
    assign shr_res  = input_a >> amt;
    assign shra_res = $signed(input_a) >>> amt;
    // Rotations come out of a doubled operand so amount 0 needs no special case.
    assign rol_wide = {input_a, input_a} << amt;
    assign ror_wide = {input_a, input_a} >> amt;

    assign a_ext = {{WIDTH{input_a[WIDTH-1]}}, input_a};
    assign b_ext = {{WIDTH{input_b[WIDTH-1]}}, input_b};
    assign prod  = a_ext * b_ext;

    assign a_s = input_a;
    assign b_s = input_b;

    // Divide-by-zero and the single overflowing quotient have fixed answers.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (input_b == '0) begin
            quot = '1;
            rem  = input_a;
        end else if (input_a == {1'b1, {(WIDTH-1){1'b0}}} && input_b == '1) begin
            quot = input_a;
            rem  = '0;
        end else begin
            quot = a_s / b_s;
            rem  = a_s % b_s;
        end
    end

    always_comb begin
        result_d = '0;
        case (opcode)
            OP_OR:   result_d = {{WIDTH{1'b0}}, input_a | input_b};
            OP_AND:  result_d = {{WIDTH{1'b0}}, input_a & input_b};
            OP_NOT:  result_d = {{WIDTH{1'b0}}, ~input_a};
            OP_ADD:  result_d = {{WIDTH{1'b0}}, input_a + input_b};
            OP_SUB:  result_d = {{WIDTH{1'b0}}, input_a - input_b};
            OP_NEG:  result_d = {{WIDTH{1'b0}}, -input_a};
            OP_MUL:  result_d = prod;
            OP_DIV:  result_d = {rem, quot};
            OP_SHL:  result_d = {{WIDTH{1'b0}}, shl_res};
            OP_SHR:  result_d = {{WIDTH{1'b0}}, shr_res};
            OP_SHRA: result_d = {{WIDTH{1'b0}}, shra_res};
            OP_ROL:  result_d = {{WIDTH{1'b0}}, rol_wide[2*WIDTH-1:WIDTH]};
            OP_ROR:  result_d = {{WIDTH{1'b0}}, ror_wide[WIDTH-1:0]};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign ALU_result = result_q;

`ifdef ALU_FLAGS_EN
    logic zero_d;
    logic neg_d;
    logic zero_q;
    logic neg_q;

    // MUL is the only op whose flags look at the full 64-bit result.
    always_comb begin
        zero_d = (result_d[WIDTH-1:0] == '0);
        neg_d  = result_d[WIDTH-1];
        if (opcode == OP_MUL) begin
            zero_d = (result_d == '0);
            neg_d  = result_d[2*WIDTH-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign zero_flag = zero_q;
    assign neg_flag  = neg_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed spec vectors plus random ops against a reference model.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;

  logic        clock;
  logic        reset;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic [3:0]  opcode;
  logic [63:0] ALU_result;
`ifdef ALU_FLAGS_EN
  logic        zero_flag;
  logic        neg_flag;
`endif

  int checks;
  int failures;

  logic [63:0] exp_q[$];
  logic [1:0]  expf_q[$];
  string       tag_q[$];

  alu dut (
    .clock      (clock),
    .reset      (reset),
    .input_a    (input_a),
    .input_b    (input_b),
    .opcode     (opcode),
    .ALU_result (ALU_result)
`ifdef ALU_FLAGS_EN
    ,
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // reference model: plain integer arithmetic from the opcode table
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    longint sa, sb, q, rm;
    int si;
    int n;
    n = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0;
    case (op)
      4'd0: r = a | b;
      4'd1: r = a & b;
      4'd2: r = ~a;
      4'd3: r = a + b;
      4'd4: r = a - b;
      4'd5: r = 32'd0 - a;
      4'd6: return 64'(sa * sb);
      4'd7: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        rm = sa - q * sb;
        return {rm[31:0], q[31:0]};
      end
      4'd8: r = a << n;
      4'd9: r = a >> n;
      4'd10: begin
        si = $signed(a);
        si = si >>> n;
        r = si;
      end
      4'd11: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
      end
      4'd12: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      end
      default: r = 32'd0;
    endcase
    return {32'd0, r};
  endfunction

  function automatic logic [1:0] flags_of(input logic [63:0] res, input logic [3:0] op, input logic rst);
    if (rst) return 2'b00;
    if (op == 4'd6) return {res == 64'd0, res[63]};
    return {res[31:0] == 32'd0, res[31]};
  endfunction

  task automatic pop_check();
    logic [63:0] e;
    logic [1:0]  ef;
    string t;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    ef = expf_q.pop_front();
    t = tag_q.pop_front();
    check(t, ALU_result, e);
`ifdef ALU_FLAGS_EN
    check({t, "_zf"}, {63'd0, zero_flag}, {63'd0, ef[1]});
    check({t, "_nf"}, {63'd0, neg_flag}, {63'd0, ef[0]});
`endif
  endtask

  // driver: one operation per cycle; result of the previous cycle is checked first
  task automatic step(input string tag, input logic rst, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] op, input logic [63:0] exp);
    @(negedge clock);
    pop_check();
    reset = rst;
    input_a = a;
    input_b = b;
    opcode = op;
    exp_q.push_back(rst ? 64'd0 : exp);
    expf_q.push_back(flags_of(rst ? 64'd0 : exp, op, rst));
    tag_q.push_back(tag);
  endtask

  task automatic step_model(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    step(tag, 1'b0, a, b, op, model(a, b, op));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    input_a = 32'd0;
    input_b = 32'd0;
    opcode = 4'd0;

    // reset handling
    step("rst0", 1'b1, 32'd20, 32'd5, 4'd3, 64'd0);
    step("rst1", 1'b1, 32'd20, 32'd5, 4'd3, 64'd0);
    step("add_after_rst", 1'b0, 32'd20, 32'd5, 4'd3, 64'd25);

    // logic and arithmetic, back to back
    step("or",  1'b0, 32'd20, 32'd5, 4'd0, 64'd21);
    step("and", 1'b0, 32'd20, 32'd5, 4'd1, 64'd4);
    step("not", 1'b0, 32'd20, 32'd5, 4'd2, 64'h0000_0000_FFFF_FFEB);
    step("add", 1'b0, 32'd20, 32'd5, 4'd3, 64'd25);
    step("sub", 1'b0, 32'd20, 32'd5, 4'd4, 64'd15);
    step("neg", 1'b0, 32'd20, 32'd5, 4'd5, 64'h0000_0000_FFFF_FFEC);
    step("neg_min", 1'b0, 32'h8000_0000, 32'd0, 4'd5, 64'h0000_0000_8000_0000);
    step("mid_rst", 1'b1, 32'd20, 32'd5, 4'd3, 64'd0);

    // multiply / divide
    step("mul", 1'b0, 32'd20, 32'd5, 4'd6, 64'd100);
    step("div", 1'b0, 32'd20, 32'd5, 4'd7, 64'd4);
    step("div_neg", 1'b0, 32'hFFFF_FFF9, 32'd2, 4'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    step("mul_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 64'd1);
    step("div_zero", 1'b0, 32'd9, 32'd0, 4'd7, 64'h0000_0009_FFFF_FFFF);
    step("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 64'h0000_0000_8000_0000);
    step("mul_big", 1'b0, 32'h0001_0000, 32'h0001_0000, 4'd6, 64'h0000_0001_0000_0000);

    // shifts and rotates
    step("shl",  1'b0, 32'd178, 32'd2, 4'd8, 64'd712);
    step("shr",  1'b0, 32'd178, 32'd2, 4'd9, 64'd44);
    step("rol",  1'b0, 32'd178, 32'd2, 4'd11, 64'd712);
    step("ror",  1'b0, 32'd178, 32'd2, 4'd12, 64'h0000_0000_8000_002C);
    step("shra", 1'b0, 32'h8000_0000, 32'd4, 4'd10, 64'h0000_0000_F800_0000);
    step("shl0", 1'b0, 32'd178, 32'd0, 4'd8, 64'hB2);
    step("ror0", 1'b0, 32'd178, 32'hFFFF_FFE0, 4'd12, 64'hB2);

    // reserved opcodes
    step("res13", 1'b0, 32'd178, 32'd2, 4'd13, 64'd0);
    step("res14", 1'b0, 32'd178, 32'd2, 4'd14, 64'd0);
    step("res15", 1'b0, 32'd178, 32'd2, 4'd15, 64'd0);

    // flag vectors
    step("sub_eq", 1'b0, 32'd5, 32'd5, 4'd4, 64'd0);
    step("sub_lt", 1'b0, 32'd3, 32'd5, 4'd4, 64'h0000_0000_FFFF_FFFE);

    // random stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(0, 40));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 31) == 0) step("rnd_rst", 1'b1, ra, rb, rop, 64'd0);
      else step_model($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop);
    end

    @(negedge clock);
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
